// File: rtl/serial_subtractor_if.sv
// Purpose: start/busy/done operand and result bundle for the bit-serial subtractor.
// Latency: none, wires only; the ovf member exists only when SUB_OVF_EN is defined.
// Backpressure: none; the controller waits for done before issuing the next start.
interface serial_subtractor_if #(
    parameter int N = 4
) ();
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;

    modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Purpose: bit-serial N-bit subtractor diff = a - b - bin, one full-subtractor cell reused LSB first.
// Latency: start accepted at edge 0, done pulses during cycle N+1 with diff/bout (and ovf) valid.
// Backpressure: start is only sampled in IDLE; starts while busy or done are dropped, not queued.
// Optional signed-overflow output is enabled by defining SUB_OVF_EN.
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   sub
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  ra_q, ra_d;
    logic [N-1:0]  rb_q, rb_d;
    logic          br_q, br_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          bout_q, bout_d;
`ifdef SUB_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    // cell inputs for the bit being processed this cycle
    logic cx, cy, cd, cb;

    // full-subtractor cell: difference and next borrow from the current LSBs and held borrow
    always_comb begin
        cx = ra_q[0];
        cy = rb_q[0];
        cd = cx ^ cy ^ br_q;
        cb = (~cx & cy) | (~(cx ^ cy) & br_q);
    end

    // next-state and datapath control for IDLE -> SHIFT -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        br_d    = br_q;
        count_d = count_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (sub.start) begin
                    ra_d    = sub.a;
                    rb_d    = sub.b;
                    br_d    = sub.bin;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                br_d    = cb;
                ra_d    = ra_q >> 1;
                rb_d    = rb_q >> 1;
                res_d   = {cd, res_q[N-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    // publish on the way into DONE so results line up with the done pulse
                    diff_d  = {cd, res_q[N-1:1]};
                    bout_d  = cb;
`ifdef SUB_OVF_EN
                    // sign bits of a, b and diff are this cycle's cell values
                    ovf_d   = (cx ^ cy) & (cd ^ cx);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            br_q    <= 1'b0;
            count_q <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            br_q    <= br_d;
            count_q <= count_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // status and result outputs straight from registered state
    always_comb begin
        sub.busy = (state_q == SHIFT);
        sub.done = (state_q == DONE);
        sub.diff = diff_q;
        sub.bout = bout_q;
`ifdef SUB_OVF_EN
        sub.ovf  = ovf_q;
`endif
    end
endmodule
